// File: rtl/pe_array_operand_feeder_if.sv
// Operand-feeder bus. It carries tile control and SRAM read data into the feeder,
// and the SRAM read strobe plus the skewed PE-array operands and phases out of it.
interface pe_array_operand_feeder_if #(
  parameter int unsigned PE_ARRAY_NUM_ROWS = 32,
  parameter int unsigned PE_ARRAY_NUM_COLS = 32,
  parameter int unsigned OPND_BWIDTH       = 8,
  parameter int unsigned K_LOG2            = 8
);
  logic                                       STALL;
  logic                                       START_in;
  logic [K_LOG2:0]                            K_in;
  logic [PE_ARRAY_NUM_ROWS*OPND_BWIDTH-1:0]   OPND1_SRAM_DATA_in;
  logic [PE_ARRAY_NUM_COLS*OPND_BWIDTH-1:0]   OPND2_SRAM_DATA_in;
  logic                                       SRAM_RD_EN_out;
  logic [K_LOG2-1:0]                          SRAM_RD_ADDR_out;
  logic                                       IS_COMPUTING_out;
  logic                                       IS_FLUSHING_out;
  logic [PE_ARRAY_NUM_ROWS-1:0]               OPND1_IS_VALID_out;
  logic [PE_ARRAY_NUM_COLS-1:0]               OPND2_IS_VALID_out;
  logic [PE_ARRAY_NUM_ROWS*OPND_BWIDTH-1:0]   OPND1_DATA_out;
  logic [PE_ARRAY_NUM_COLS*OPND_BWIDTH-1:0]   OPND2_DATA_out;
  logic                                       BUSY_out;
  logic                                       DONE_out;

  modport master (
    input  STALL, START_in, K_in, OPND1_SRAM_DATA_in, OPND2_SRAM_DATA_in,
    output SRAM_RD_EN_out, SRAM_RD_ADDR_out, IS_COMPUTING_out, IS_FLUSHING_out,
           OPND1_IS_VALID_out, OPND2_IS_VALID_out, OPND1_DATA_out, OPND2_DATA_out,
           BUSY_out, DONE_out
  );

  modport slave (
    output STALL, START_in, K_in, OPND1_SRAM_DATA_in, OPND2_SRAM_DATA_in,
    input  SRAM_RD_EN_out, SRAM_RD_ADDR_out, IS_COMPUTING_out, IS_FLUSHING_out,
           OPND1_IS_VALID_out, OPND2_IS_VALID_out, OPND1_DATA_out, OPND2_DATA_out,
           BUSY_out, DONE_out
  );
endinterface

// File: rtl/pe_array_operand_feeder.sv
// PE-array operand feeder. It reads K operand rows, drives them diagonally skewed into the array,
// sequences the compute and flush phases for one tile, and then pulses DONE.
module pe_array_operand_feeder #(
  parameter int unsigned PE_ARRAY_NUM_ROWS = 32,
  parameter int unsigned PE_ARRAY_NUM_COLS = 32,
  parameter int unsigned OPND_BWIDTH       = 8,
  parameter int unsigned K_LOG2            = 8
) (
  input  logic                      CLK,
  input  logic                      RSTn,
  pe_array_operand_feeder_if.master opnd_if
);

  localparam int unsigned DRAIN_LEN = PE_ARRAY_NUM_ROWS + PE_ARRAY_NUM_COLS + 1;
  localparam int unsigned CNT_W     = $clog2(DRAIN_LEN);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_LEN - 1);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(PE_ARRAY_NUM_ROWS - 1);
  localparam int unsigned SW = OPND_BWIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_DRAIN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [K_LOG2:0]    r_k;
  logic [K_LOG2-1:0]  r_addr;
  logic [CNT_W-1:0]   r_phase_cnt;
  logic               r_computing;
  logic               r_flushing;
  logic               r_busy;
  logic               r_done;
  logic               r_dv;
  logic               w_rd_en;
  logic               w_last_addr;

  assign w_rd_en     = (r_state == S_FILL) & ~opnd_if.STALL;
  assign w_last_addr = ({1'b0, r_addr} == (r_k - 1'b1));

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state     <= S_IDLE;
      r_k         <= '0;
      r_addr      <= '0;
      r_phase_cnt <= '0;
      r_computing <= 1'b0;
      r_flushing  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (!opnd_if.STALL) begin
      case (r_state)
        S_IDLE: begin
          if (opnd_if.START_in) begin
            r_k    <= opnd_if.K_in;
            r_addr <= '0;
            r_busy <= 1'b1;
            if (opnd_if.K_in == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FILL;
              r_computing <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_last_addr) begin
            r_state     <= S_DRAIN;
            r_addr      <= '0;
            r_phase_cnt <= '0;
          end else begin
            r_addr <= r_addr + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_phase_cnt == DRAIN_LAST) begin
            r_state     <= S_FLUSH;
            r_phase_cnt <= '0;
            r_computing <= 1'b0;
            r_flushing  <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        S_FLUSH: begin
          if (r_phase_cnt == FLUSH_LAST) begin
            r_state     <= S_DONE;
            r_phase_cnt <= '0;
            r_flushing  <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_phase_cnt <= r_phase_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_addr      <= '0;
          r_phase_cnt <= '0;
          r_computing <= 1'b0;
          r_flushing  <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  // The SRAM holds its data between reads, so r_dv marks the one cycle in which that data is a new row.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_dv <= 1'b0;
    end else if (!opnd_if.STALL) begin
      r_dv <= w_rd_en;
    end
  end

  assign opnd_if.SRAM_RD_EN_out   = w_rd_en;
  assign opnd_if.SRAM_RD_ADDR_out = r_addr;
  assign opnd_if.IS_COMPUTING_out = r_computing;
  assign opnd_if.IS_FLUSHING_out  = r_flushing;
  assign opnd_if.BUSY_out         = r_busy;
  assign opnd_if.DONE_out         = r_done;

  // Each lane's chain packs {valid, data} per stage. Stage 0 is the low slice and the output stage is the top slice.
  for (genvar gi = 0; gi < PE_ARRAY_NUM_ROWS; gi++) begin : g_opnd1_lane
    localparam int unsigned CW = (gi + 1) * SW;
    logic [CW-1:0] r_chain;
    logic [SW-1:0] w_head;

    assign w_head = r_dv ? {1'b1, opnd_if.OPND1_SRAM_DATA_in[gi*OPND_BWIDTH +: OPND_BWIDTH]} : '0;

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        r_chain <= '0;
      end else if (!opnd_if.STALL) begin
        r_chain <= (r_chain << SW) | CW'(w_head);
      end
    end

    assign opnd_if.OPND1_IS_VALID_out[gi]                          = r_chain[CW-1];
    assign opnd_if.OPND1_DATA_out[gi*OPND_BWIDTH +: OPND_BWIDTH]   = r_chain[CW-2 -: OPND_BWIDTH];
  end

  for (genvar gj = 0; gj < PE_ARRAY_NUM_COLS; gj++) begin : g_opnd2_lane
    localparam int unsigned CW = (gj + 1) * SW;
    logic [CW-1:0] r_chain;
    logic [SW-1:0] w_head;

    assign w_head = r_dv ? {1'b1, opnd_if.OPND2_SRAM_DATA_in[gj*OPND_BWIDTH +: OPND_BWIDTH]} : '0;

    always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
        r_chain <= '0;
      end else if (!opnd_if.STALL) begin
        r_chain <= (r_chain << SW) | CW'(w_head);
      end
    end

    assign opnd_if.OPND2_IS_VALID_out[gj]                          = r_chain[CW-1];
    assign opnd_if.OPND2_DATA_out[gj*OPND_BWIDTH +: OPND_BWIDTH]   = r_chain[CW-2 -: OPND_BWIDTH];
  end

endmodule

// File: tb/tb_pe_array_operand_feeder.sv
// Self-checking bench for pe_array_operand_feeder. It combines a table of fixed tile vectors,
// hand-written stall/K=0/ignored-start/reset sequences, and random traffic checked against a timeline model.
module tb_pe_array_operand_feeder;
  localparam int R  = 4;
  localparam int C  = 4;
  localparam int W  = 8;
  localparam int KL = 8;
  localparam int KW = KL + 1;
  localparam int TILE_TAIL = 2*R + C + 2;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  pe_array_operand_feeder_if #(
    .PE_ARRAY_NUM_ROWS(R), .PE_ARRAY_NUM_COLS(C), .OPND_BWIDTH(W), .K_LOG2(KL)
  ) bus ();

  pe_array_operand_feeder #(
    .PE_ARRAY_NUM_ROWS(R), .PE_ARRAY_NUM_COLS(C), .OPND_BWIDTH(W), .K_LOG2(KL)
  ) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .opnd_if(bus)
  );

  // SRAM model: a read of addr k returns 16*k+i on lane i one cycle later, then holds it.
  logic [R*W-1:0] r_sram1 = '0;
  logic [C*W-1:0] r_sram2 = '0;
  assign bus.OPND1_SRAM_DATA_in = r_sram1;
  assign bus.OPND2_SRAM_DATA_in = r_sram2;
  always @(posedge CLK) begin
    if (bus.SRAM_RD_EN_out) begin
      for (int i = 0; i < R; i++) r_sram1[i*W +: W] <= W'(16*int'(bus.SRAM_RD_ADDR_out) + i);
      for (int i = 0; i < C; i++) r_sram2[i*W +: W] <= W'(16*int'(bus.SRAM_RD_ADDR_out) + i);
    end
  end

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  // Reference model: t counts unstalled edges since the START edge, which is the no-stall timeline.
  bit m_active = 1'b0;
  int m_t      = 0;
  int m_k      = 0;

  logic           o_rd, o_comp, o_flush, o_busy, o_done;
  logic [KL-1:0]  o_addr;
  logic [R-1:0]   o_v1;
  logic [R*W-1:0] o_d1;
  logic [C-1:0]   o_v2;
  logic [C*W-1:0] o_d2;

  typedef struct {
    int start; int rd; int addr; int comp; int flush; int busy; int done; int v; int d;
  } vec_t;
  vec_t tbl [18];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  function automatic int m_end();
    return (m_k == 0) ? 1 : m_k + TILE_TAIL;
  endfunction

  task automatic model_step(input int stall, input int start, input int k);
    if (stall == 0) begin
      if (m_active) begin
        if (m_t == m_end()) m_active = 1'b0;
        else m_t++;
      end else if (start != 0) begin
        m_active = 1'b1;
        m_t      = 1;
        m_k      = k;
      end
    end
  endtask

  task automatic model_check(input int stall);
    bit a, fill, comp, flush, done;
    int t, k;
    logic [R-1:0]   ev1;
    logic [R*W-1:0] ed1;
    logic [C-1:0]   ev2;
    logic [C*W-1:0] ed2;
    a = m_active; t = m_t; k = m_k;
    fill  = a && k > 0 && t <= k;
    comp  = a && k > 0 && t <= k + R + C + 1;
    flush = a && k > 0 && t > k + R + C + 1 && t <= k + 2*R + C + 1;
    done  = a && t == m_end();
    ev1 = '0; ed1 = '0; ev2 = '0; ed2 = '0;
    for (int i = 0; i < R; i++)
      if (a && k > 0 && t >= 3 + i && t <= 2 + i + k) begin
        ev1[i] = 1'b1;
        ed1[i*W +: W] = W'(16*(t - 3 - i) + i);
      end
    for (int i = 0; i < C; i++)
      if (a && k > 0 && t >= 3 + i && t <= 2 + i + k) begin
        ev2[i] = 1'b1;
        ed2[i*W +: W] = W'(16*(t - 3 - i) + i);
      end
    chk("rd_en", 64'(o_rd), 64'(fill && stall == 0));
    if (fill && stall == 0) chk("rd_addr", 64'(o_addr), 64'(t - 1));
    chk("is_computing", 64'(o_comp), 64'(comp));
    chk("is_flushing", 64'(o_flush), 64'(flush));
    chk("busy", 64'(o_busy), 64'(a));
    chk("done", 64'(o_done), 64'(done));
    chk("opnd1_valid", 64'(o_v1), 64'(ev1));
    chk("opnd1_data", 64'(o_d1), 64'(ed1));
    chk("opnd2_valid", 64'(o_v2), 64'(ev2));
    chk("opnd2_data", 64'(o_d2), 64'(ed2));
  endtask

  // One clock cycle: drive inputs, sample and check at the falling edge, and advance the model at the rising edge.
  task automatic cycle(input int stall, input int start, input int k);
    bus.STALL    = (stall != 0);
    bus.START_in = (start != 0);
    bus.K_in     = KW'(k);
    @(negedge CLK);
    o_rd = bus.SRAM_RD_EN_out;  o_addr = bus.SRAM_RD_ADDR_out;
    o_comp = bus.IS_COMPUTING_out; o_flush = bus.IS_FLUSHING_out;
    o_busy = bus.BUSY_out; o_done = bus.DONE_out;
    o_v1 = bus.OPND1_IS_VALID_out; o_d1 = bus.OPND1_DATA_out;
    o_v2 = bus.OPND2_IS_VALID_out; o_d2 = bus.OPND2_DATA_out;
    model_check(stall);
    @(posedge CLK);
    model_step(stall, start, k);
    cyc++;
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_en"}, 64'(bus.SRAM_RD_EN_out), 64'(0));
    chk({tag, "_addr"}, 64'(bus.SRAM_RD_ADDR_out), 64'(0));
    chk({tag, "_computing"}, 64'(bus.IS_COMPUTING_out), 64'(0));
    chk({tag, "_flushing"}, 64'(bus.IS_FLUSHING_out), 64'(0));
    chk({tag, "_busy"}, 64'(bus.BUSY_out), 64'(0));
    chk({tag, "_done"}, 64'(bus.DONE_out), 64'(0));
    chk({tag, "_v1"}, 64'(bus.OPND1_IS_VALID_out), 64'(0));
    chk({tag, "_d1"}, 64'(bus.OPND1_DATA_out), 64'(0));
    chk({tag, "_v2"}, 64'(bus.OPND2_IS_VALID_out), 64'(0));
    chk({tag, "_d2"}, 64'(bus.OPND2_DATA_out), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd_mask, done_c, l3_c, n_rd, n_done, seen_phase, st, sr, r, kk;

    // K=3 tile with no stall, indexed by cycle relative to the START-sampling cycle.
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 'h0, 'h00000000};
    tbl[1]  = '{0, 1, 0, 1, 0, 1, 0, 'h0, 'h00000000};
    tbl[2]  = '{0, 1, 1, 1, 0, 1, 0, 'h0, 'h00000000};
    tbl[3]  = '{0, 1, 2, 1, 0, 1, 0, 'h1, 'h00000000};
    tbl[4]  = '{0, 0, 0, 1, 0, 1, 0, 'h3, 'h00000110};
    tbl[5]  = '{0, 0, 0, 1, 0, 1, 0, 'h7, 'h00021120};
    tbl[6]  = '{0, 0, 0, 1, 0, 1, 0, 'he, 'h03122100};
    tbl[7]  = '{0, 0, 0, 1, 0, 1, 0, 'hc, 'h13220000};
    tbl[8]  = '{0, 0, 0, 1, 0, 1, 0, 'h8, 'h23000000};
    for (int c = 9; c <= 12; c++)  tbl[c] = '{0, 0, 0, 1, 0, 1, 0, 'h0, 'h00000000};
    for (int c = 13; c <= 16; c++) tbl[c] = '{0, 0, 0, 0, 1, 1, 0, 'h0, 'h00000000};
    tbl[17] = '{0, 0, 0, 0, 0, 1, 1, 'h0, 'h00000000};

    bus.STALL = 1'b0; bus.START_in = 1'b0; bus.K_in = '0;
    #12;
    check_all_zero("reset");
    RSTn = 1'b1;
    @(posedge CLK); #1;
    for (int c = 0; c < 3; c++) cycle(0, 0, 0);

    // The table is applied twice in a row, so the second pass restarts in the cycle right after DONE.
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 18; c++) begin
        cycle(0, tbl[c].start, 3);
        chk("tbl_rd_en", 64'(o_rd), 64'(tbl[c].rd));
        if (tbl[c].rd != 0) chk("tbl_addr", 64'(o_addr), 64'(tbl[c].addr));
        chk("tbl_computing", 64'(o_comp), 64'(tbl[c].comp));
        chk("tbl_flushing", 64'(o_flush), 64'(tbl[c].flush));
        chk("tbl_busy", 64'(o_busy), 64'(tbl[c].busy));
        chk("tbl_done", 64'(o_done), 64'(tbl[c].done));
        chk("tbl_v1", 64'(o_v1), 64'(tbl[c].v));
        chk("tbl_d1", 64'(o_d1), 64'(tbl[c].d));
        chk("tbl_v2", 64'(o_v2), 64'(tbl[c].v));
        chk("tbl_d2", 64'(o_d2), 64'(tbl[c].d));
      end
    end
    for (int c = 0; c < 2; c++) cycle(0, 0, 0);

    // K=3 with STALL held in cycles 2-3.
    rd_mask = 0; done_c = -1; l3_c = -1;
    for (int c = 0; c < 22; c++) begin
      cycle((c == 2 || c == 3) ? 1 : 0, (c == 0) ? 1 : 0, 3);
      if (o_rd) rd_mask |= (1 << c);
      if (o_done && done_c < 0) done_c = c;
      if (o_v1[3] && o_d1[31:24] == 8'h03 && l3_c < 0) l3_c = c;
    end
    chk("stall_read_cycles", 64'(rd_mask), 64'((1 << 1) | (1 << 4) | (1 << 5)));
    chk("stall_done_cycle", 64'(done_c), 64'(19));
    chk("stall_lane3_first", 64'(l3_c), 64'(8));

    // START with K_in=7 in the middle of a K=3 tile must be ignored.
    n_rd = 0; n_done = 0;
    for (int c = 0; c < 25; c++) begin
      cycle(0, (c == 0 || c == 5) ? 1 : 0, (c == 5) ? 7 : 3);
      if (o_rd) n_rd++;
      if (o_done) n_done++;
    end
    chk("ignored_start_reads", 64'(n_rd), 64'(3));
    chk("ignored_start_dones", 64'(n_done), 64'(1));

    // Reset pulse in the middle of DRAIN.
    for (int c = 0; c < 7; c++) cycle(0, (c == 0) ? 1 : 0, 3);
    RSTn = 1'b0;
    #1;
    check_all_zero("mid_reset");
    m_active = 1'b0;
    #1;
    RSTn = 1'b1;
    for (int c = 0; c < 3; c++) cycle(0, 0, 0);

    // K=0 goes straight to DONE and never reads or enters a phase.
    n_rd = 0; done_c = -1; seen_phase = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(0, (c == 0) ? 1 : 0, 0);
      if (o_rd) n_rd++;
      if (o_comp || o_flush) seen_phase = 1;
      if (o_done && done_c < 0) done_c = c;
    end
    chk("k0_reads", 64'(n_rd), 64'(0));
    chk("k0_phases", 64'(seen_phase), 64'(0));
    chk("k0_done_cycle", 64'(done_c), 64'(1));

    // Random traffic: stalls, starts (also while busy), K from 0 up to the maximum 256.
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(0, 3) == 0) ? 1 : 0;
      sr = ($urandom_range(0, 2) == 0) ? 1 : 0;
      r  = int'($urandom_range(0, 15));
      kk = (r == 0) ? 256 : (r == 1) ? 0 : int'($urandom_range(1, 12));
      cycle(st, sr, kk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
